// File: rtl/ip_arp_resolver_multi.sv
// Outgoing-IP destination MAC resolver: multi-entry IP->MAC cache with per-entry aging and ARP fallback.
// Define ARP_RESOLVER_STATS_EN to add saturating hit/miss/drop statistics counters.
module ip_arp_resolver_multi #(
   parameter int          CACHE_ENTRIES = 4,
   parameter logic [31:0] ENTRY_TIMEOUT = 32'd125000000,
   parameter int          STAT_WIDTH    = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_ip_hdr_valid,
   output logic        s_ip_hdr_ready,
   input  logic [31:0] s_ip_dest_ip,
   output logic        m_hdr_valid,
   input  logic        m_hdr_ready,
   output logic [47:0] m_eth_dest_mac,
   input  logic        s_ip_payload_axis_tvalid,
   output logic        s_ip_payload_axis_tready,
   input  logic        s_ip_payload_axis_tlast,
   output logic        m_ip_payload_axis_tvalid,
   input  logic        m_ip_payload_axis_tready,
   output logic        arp_request_valid,
   input  logic        arp_request_ready,
   output logic [31:0] arp_request_ip,
   input  logic        arp_response_valid,
   output logic        arp_response_ready,
   input  logic        arp_response_error,
   input  logic [47:0] arp_response_mac,
   input  logic        cache_flush,
   output logic        tx_error_arp_failed,
   output logic        busy
`ifdef ARP_RESOLVER_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] stat_hit_count,
   output logic [STAT_WIDTH-1:0] stat_miss_count,
   output logic [STAT_WIDTH-1:0] stat_drop_count
`endif
);

   localparam int PTR_W = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_HDR_OUT  = 3'd1;
   localparam logic [2:0] S_ARP_REQ  = 3'd2;
   localparam logic [2:0] S_ARP_WAIT = 3'd3;
   localparam logic [2:0] S_FORWARD  = 3'd4;
   localparam logic [2:0] S_DROP     = 3'd5;

   if (CACHE_ENTRIES < 1 || CACHE_ENTRIES > 16 || STAT_WIDTH < 1) begin : g_param_check
      $error("ip_arp_resolver_multi: CACHE_ENTRIES must be 1..16 and STAT_WIDTH >= 1");
   end

   logic [2:0]               state;
   logic [CACHE_ENTRIES-1:0] cache_vld;
   logic [CACHE_ENTRIES-1:0] vld_nxt;
   logic [CACHE_ENTRIES-1:0] expire;
   logic [31:0]              cache_ip  [CACHE_ENTRIES];
   logic [47:0]              cache_mac [CACHE_ENTRIES];
   logic [31:0]              cache_age [CACHE_ENTRIES];
   logic [PTR_W-1:0]         rr_ptr;
   logic [PTR_W-1:0]         hit_idx;
   logic [PTR_W-1:0]         free_idx;
   logic [PTR_W-1:0]         ins_idx;
   logic                     hit;
   logic                     free_found;
   logic                     ins;

   // Descending scan so the lowest matching / lowest free index is the one left standing.
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = CACHE_ENTRIES - 1; i >= 0; i--) begin
         if (cache_vld[i] && (cache_ip[i] == s_ip_dest_ip)) begin
            hit     = 1'b1;
            hit_idx = PTR_W'(i);
         end
         if (!cache_vld[i]) begin
            free_found = 1'b1;
            free_idx   = PTR_W'(i);
         end
      end
   end

   always_comb begin
      expire = '0;
      for (int i = 0; i < CACHE_ENTRIES; i++) begin
         expire[i] = (ENTRY_TIMEOUT != 32'd0) && cache_vld[i] &&
                     (cache_age[i] == ENTRY_TIMEOUT - 32'd1);
      end
   end

   assign ins     = (state == S_ARP_WAIT) && arp_response_valid && !arp_response_error;
   assign ins_idx = free_found ? free_idx : rr_ptr;

   // Flush overrides a same-cycle insert; an insert overrides expiry of the slot it reuses.
   always_comb begin
      vld_nxt = cache_vld & ~expire;
      if (ins) begin
         vld_nxt[ins_idx] = 1'b1;
      end
      if (cache_flush) begin
         vld_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CACHE_ENTRIES; i++) begin
         if (ins && (ins_idx == PTR_W'(i))) begin
            cache_ip[i]  <= arp_request_ip;
            cache_mac[i] <= arp_response_mac;
            cache_age[i] <= '0;
         end else if (cache_vld[i]) begin
            cache_age[i] <= cache_age[i] + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= S_IDLE;
         cache_vld           <= '0;
         rr_ptr              <= '0;
         m_hdr_valid         <= 1'b0;
         m_eth_dest_mac      <= '0;
         s_ip_hdr_ready      <= 1'b0;
         arp_request_valid   <= 1'b0;
         arp_request_ip      <= '0;
         tx_error_arp_failed <= 1'b0;
      end else begin
         cache_vld           <= vld_nxt;
         s_ip_hdr_ready      <= 1'b0;
         tx_error_arp_failed <= 1'b0;
         if (ins && !free_found) begin
            rr_ptr <= (rr_ptr == PTR_W'(CACHE_ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (s_ip_hdr_valid) begin
                  if (hit) begin
                     m_eth_dest_mac <= cache_mac[hit_idx];
                     m_hdr_valid    <= 1'b1;
                     s_ip_hdr_ready <= 1'b1;
                     state          <= S_HDR_OUT;
                  end else begin
                     arp_request_valid <= 1'b1;
                     arp_request_ip    <= s_ip_dest_ip;
                     state             <= S_ARP_REQ;
                  end
               end
            end
            S_ARP_REQ: begin
               if (arp_request_ready) begin
                  arp_request_valid <= 1'b0;
                  state             <= S_ARP_WAIT;
               end
            end
            S_ARP_WAIT: begin
               if (arp_response_valid) begin
                  s_ip_hdr_ready <= 1'b1;
                  if (arp_response_error) begin
                     tx_error_arp_failed <= 1'b1;
                     state               <= S_DROP;
                  end else begin
                     m_eth_dest_mac <= arp_response_mac;
                     m_hdr_valid    <= 1'b1;
                     state          <= S_HDR_OUT;
                  end
               end
            end
            S_HDR_OUT: begin
               if (m_hdr_ready) begin
                  m_hdr_valid <= 1'b0;
                  state       <= S_FORWARD;
               end
            end
            S_FORWARD: begin
               if (s_ip_payload_axis_tvalid && m_ip_payload_axis_tready && s_ip_payload_axis_tlast) begin
                  state <= S_IDLE;
               end
            end
            S_DROP: begin
               if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      s_ip_payload_axis_tready = 1'b0;
      m_ip_payload_axis_tvalid = 1'b0;
      case (state)
         S_FORWARD: begin
            s_ip_payload_axis_tready = m_ip_payload_axis_tready;
            m_ip_payload_axis_tvalid = s_ip_payload_axis_tvalid;
         end
         S_DROP:    s_ip_payload_axis_tready = 1'b1;
         default: ;
      endcase
   end

   assign arp_response_ready = (state == S_ARP_WAIT);
   assign busy               = (state != S_IDLE);

`ifdef ARP_RESOLVER_STATS_EN
   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hit_count  <= '0;
         stat_miss_count <= '0;
         stat_drop_count <= '0;
      end else begin
         if ((state == S_IDLE) && s_ip_hdr_valid && hit) begin
            stat_hit_count <= sat_inc(stat_hit_count);
         end
         if ((state == S_IDLE) && s_ip_hdr_valid && !hit) begin
            stat_miss_count <= sat_inc(stat_miss_count);
         end
         if (tx_error_arp_failed) begin
            stat_drop_count <= sat_inc(stat_drop_count);
         end
      end
   end
`endif

endmodule

// File: tb/tb_ip_arp_resolver_multi.sv
// Directed self-checking bench for ip_arp_resolver_multi (4 entries, 100-cycle entry lifetime).
module tb_ip_arp_resolver_multi;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_ip_hdr_valid = 1'b0;
   logic        s_ip_hdr_ready;
   logic [31:0] s_ip_dest_ip = '0;
   logic        m_hdr_valid;
   logic        m_hdr_ready = 1'b0;
   logic [47:0] m_eth_dest_mac;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic        arp_request_valid;
   logic        arp_request_ready = 1'b0;
   logic [31:0] arp_request_ip;
   logic        arp_response_valid = 1'b0;
   logic        arp_response_ready;
   logic        arp_response_error = 1'b0;
   logic [47:0] arp_response_mac = '0;
   logic        cache_flush = 1'b0;
   logic        tx_error_arp_failed;
   logic        busy;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc_cnt  = 0;
   int last_ins = 0;

   ip_arp_resolver_multi #(
      .CACHE_ENTRIES(4),
      .ENTRY_TIMEOUT(32'd100),
      .STAT_WIDTH(32)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_ip_hdr_valid(s_ip_hdr_valid),
      .s_ip_hdr_ready(s_ip_hdr_ready),
      .s_ip_dest_ip(s_ip_dest_ip),
      .m_hdr_valid(m_hdr_valid),
      .m_hdr_ready(m_hdr_ready),
      .m_eth_dest_mac(m_eth_dest_mac),
      .s_ip_payload_axis_tvalid(s_tvalid),
      .s_ip_payload_axis_tready(s_tready),
      .s_ip_payload_axis_tlast(s_tlast),
      .m_ip_payload_axis_tvalid(m_tvalid),
      .m_ip_payload_axis_tready(m_tready),
      .arp_request_valid(arp_request_valid),
      .arp_request_ready(arp_request_ready),
      .arp_request_ip(arp_request_ip),
      .arp_response_valid(arp_response_valid),
      .arp_response_ready(arp_response_ready),
      .arp_response_error(arp_response_error),
      .arp_response_mac(arp_response_mac),
      .cache_flush(cache_flush),
      .tx_error_arp_failed(tx_error_arp_failed),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      s_ip_hdr_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; cache_flush = 1'b0;
      arp_response_valid = 1'b0; m_hdr_ready = 1'b0; m_tready = 1'b0; arp_request_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Runs one header + payload frame from a negedge; responds to ARP with rmac/rerr.
   task automatic do_frame(input logic [31:0] ip, input logic [47:0] rmac, input bit rerr,
                           input int beats, input bit flush_resp,
                           output int hdr_lat, output bit saw_arp, output logic [31:0] req_ip,
                           output logic [47:0] got_mac, output int fwd_beats, output int acc_beats,
                           output int err_pulses, output bit tmo);
      int cyc;
      bit pend;
      hdr_lat = -1; saw_arp = 1'b0; req_ip = '0; got_mac = '0;
      fwd_beats = 0; acc_beats = 0; err_pulses = 0; cyc = 0;
      s_ip_hdr_valid = 1'b1; s_ip_dest_ip = ip;
      m_hdr_ready = 1'b1; arp_request_ready = 1'b1; m_tready = 1'b1;
      s_tvalid = 1'b1; s_tlast = (beats == 1);
      while (acc_beats < beats && cyc < 200) begin
         arp_response_valid = arp_response_ready;
         arp_response_mac   = rmac;
         arp_response_error = rerr;
         cache_flush        = flush_resp && arp_response_ready;
         if (arp_response_ready) last_ins = cyc_cnt + 1;
         pend = s_tvalid && s_tready;
         if (pend && m_tvalid) fwd_beats++;
         @(negedge clk);
         cyc++;
         if (pend) begin
            acc_beats++;
            s_tlast = (acc_beats == beats - 1);
            if (acc_beats == beats) s_tvalid = 1'b0;
         end
         if (s_ip_hdr_ready) s_ip_hdr_valid = 1'b0;
         if (m_hdr_valid && hdr_lat < 0) begin
            hdr_lat = cyc;
            got_mac = m_eth_dest_mac;
         end
         if (arp_request_valid) begin
            saw_arp = 1'b1;
            req_ip  = arp_request_ip;
         end
         if (tx_error_arp_failed) err_pulses++;
      end
      arp_response_valid = 1'b0; cache_flush = 1'b0;
      s_ip_hdr_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
      tmo = (acc_beats < beats);
   endtask

   task automatic test_reset();
      do_reset();
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
      chk_cnt++; if (m_hdr_valid !== 1'b0) $display("FAIL reset_m_hdr_valid: got %0b want 0", m_hdr_valid); else pass_cnt++;
      chk_cnt++; if (arp_request_valid !== 1'b0) $display("FAIL reset_arp_req_valid: got %0b want 0", arp_request_valid); else pass_cnt++;
      chk_cnt++; if (s_ip_hdr_ready !== 1'b0) $display("FAIL reset_hdr_ready: got %0b want 0", s_ip_hdr_ready); else pass_cnt++;
      chk_cnt++; if (m_eth_dest_mac !== 48'h0) $display("FAIL reset_mac: got %h want 0", m_eth_dest_mac); else pass_cnt++;
      chk_cnt++; if (arp_request_ip !== 32'h0) $display("FAIL reset_arp_ip: got %h want 0", arp_request_ip); else pass_cnt++;
      chk_cnt++; if (s_tready !== 1'b0 || m_tvalid !== 1'b0) $display("FAIL reset_payload: got tready=%0b tvalid=%0b want 0 0", s_tready, m_tvalid); else pass_cnt++;
      chk_cnt++; if (tx_error_arp_failed !== 1'b0 || arp_response_ready !== 1'b0) $display("FAIL reset_err_rsp: got err=%0b rsp_rdy=%0b want 0 0", tx_error_arp_failed, arp_response_ready); else pass_cnt++;
   endtask

   task automatic test_cold_miss();
      int hl, fb, ab, ep; bit sa, tm; logic [31:0] rip; logic [47:0] gm;
      do_frame(32'h0A000002, 48'h020000000002, 1'b0, 4, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (sa !== 1'b1) $display("FAIL cold_arp_req: got %0b want 1", sa); else pass_cnt++;
      chk_cnt++; if (rip !== 32'h0A000002) $display("FAIL cold_arp_ip: got %h want 0a000002", rip); else pass_cnt++;
      chk_cnt++; if (gm !== 48'h020000000002) $display("FAIL cold_mac: got %h want 020000000002", gm); else pass_cnt++;
      chk_cnt++; if (hl != 3) $display("FAIL cold_hdr_latency: got %0d want 3", hl); else pass_cnt++;
      chk_cnt++; if (fb != 4 || tm) $display("FAIL cold_fwd_beats: got %0d tmo=%0b want 4 tmo=0", fb, tm); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL cold_idle: got busy=%0b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_repeat_hit();
      int hl, fb, ab, ep; bit sa, tm; logic [31:0] rip; logic [47:0] gm;
      do_frame(32'h0A000002, 48'hBAD0BAD0BAD0, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (hl != 1) $display("FAIL hit_latency: got %0d want 1", hl); else pass_cnt++;
      chk_cnt++; if (sa !== 1'b0) $display("FAIL hit_no_arp: got %0b want 0", sa); else pass_cnt++;
      chk_cnt++; if (gm !== 48'h020000000002) $display("FAIL hit_mac: got %h want 020000000002", gm); else pass_cnt++;
   endtask

   task automatic test_eviction();
      int hl, fb, ab, ep; bit sa, tm; logic [31:0] rip; logic [47:0] gm;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         do_frame(32'h0A000000 + k, 48'h020000000000 + k, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
         chk_cnt++; if (sa !== 1'b1 || tm) $display("FAIL evict_fill_miss_%0d: got arp=%0b tmo=%0b want 1 0", k, sa, tm); else pass_cnt++;
      end
      for (int k = 2; k <= 5; k++) begin
         do_frame(32'h0A000000 + k, 48'hBAD0BAD0BAD0, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
         chk_cnt++; if (sa !== 1'b0 || gm !== 48'h020000000000 + k) $display("FAIL evict_hit_%0d: got arp=%0b mac=%h want 0 %h", k, sa, gm, 48'h020000000000 + k); else pass_cnt++;
      end
      do_frame(32'h0A000001, 48'h020000000001, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (sa !== 1'b1) $display("FAIL evict_victim_miss: got %0b want 1", sa); else pass_cnt++;
   endtask

   task automatic test_arp_error();
      int hl, fb, ab, ep; bit sa, tm; logic [31:0] rip; logic [47:0] gm;
      do_frame(32'h0A000009, 48'h020000000009, 1'b1, 3, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (ep != 1) $display("FAIL err_pulse: got %0d want 1", ep); else pass_cnt++;
      chk_cnt++; if (ab != 3 || tm) $display("FAIL err_accepted: got %0d want 3", ab); else pass_cnt++;
      chk_cnt++; if (fb != 0) $display("FAIL err_no_forward: got %0d want 0", fb); else pass_cnt++;
      chk_cnt++; if (hl != -1) $display("FAIL err_no_hdr: got latency %0d want -1", hl); else pass_cnt++;
      do_frame(32'h0A000007, 48'h020000000007, 1'b0, 2, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (gm !== 48'h020000000007 || fb != 2 || ep != 0) $display("FAIL err_next_frame: got mac=%h fwd=%0d err=%0d want 020000000007 2 0", gm, fb, ep); else pass_cnt++;
      do_frame(32'h0A000009, 48'h020000000009, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (sa !== 1'b1) $display("FAIL err_not_cached: got arp=%0b want 1", sa); else pass_cnt++;
   endtask

   task automatic test_aging();
      int hl, fb, ab, ep; bit sa, tm; logic [31:0] rip; logic [47:0] gm; int ins;
      do_reset();
      do_frame(32'h0A000002, 48'h020000000002, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      ins = last_ins;
      while (cyc_cnt < ins + 99) @(negedge clk);
      do_frame(32'h0A000002, 48'hBAD0BAD0BAD0, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (sa !== 1'b0 || gm !== 48'h020000000002) $display("FAIL age_last_cycle_hit: got arp=%0b mac=%h want 0 020000000002", sa, gm); else pass_cnt++;
      do_frame(32'h0A000002, 48'h020000000002, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (sa !== 1'b1) $display("FAIL age_expired_miss: got arp=%0b want 1", sa); else pass_cnt++;
      ins = last_ins;
      while (cyc_cnt < ins + 100) @(negedge clk);
      do_frame(32'h0A000002, 48'h020000000002, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (sa !== 1'b1) $display("FAIL age_wait100_miss: got arp=%0b want 1", sa); else pass_cnt++;
   endtask

   task automatic test_flush();
      int hl, fb, ab, ep; bit sa, tm; logic [31:0] rip; logic [47:0] gm;
      do_reset();
      do_frame(32'h0A000002, 48'h020000000002, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      do_frame(32'h0A000002, 48'hBAD0BAD0BAD0, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (sa !== 1'b0) $display("FAIL flush_pre_hit: got arp=%0b want 0", sa); else pass_cnt++;
      cache_flush = 1'b1;
      @(negedge clk);
      cache_flush = 1'b0;
      do_frame(32'h0A000002, 48'h020000000002, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (sa !== 1'b1) $display("FAIL flush_then_miss: got arp=%0b want 1", sa); else pass_cnt++;
      do_frame(32'h0A000003, 48'h020000000003, 1'b0, 1, 1'b1, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (gm !== 48'h020000000003) $display("FAIL flush_insert_mac: got %h want 020000000003", gm); else pass_cnt++;
      do_frame(32'h0A000003, 48'h020000000003, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (sa !== 1'b1) $display("FAIL flush_insert_invalid: got arp=%0b want 1", sa); else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      int hl, fb, ab, ep; bit sa, tm; logic [31:0] rip; logic [47:0] gm;
      int n; bit fwd; bit hs;
      s_ip_hdr_valid = 1'b1; s_ip_dest_ip = 32'h0A000006;
      arp_request_ready = 1'b1; m_hdr_ready = 1'b1; m_tready = 1'b0;
      s_tvalid = 1'b1; s_tlast = 1'b0;
      arp_response_mac = 48'h020000000006; arp_response_error = 1'b0;
      n = 0; fwd = 1'b0;
      while (!fwd && n < 20) begin
         arp_response_valid = arp_response_ready;
         hs = m_hdr_valid && m_hdr_ready;
         @(negedge clk);
         n++;
         if (s_ip_hdr_ready) s_ip_hdr_valid = 1'b0;
         if (hs) fwd = 1'b1;
      end
      arp_response_valid = 1'b0;
      chk_cnt++; if (!fwd) $display("FAIL rstmid_reach_forward: got no header handshake in %0d cycles", n); else pass_cnt++;
      chk_cnt++; if (m_tvalid !== 1'b1 || s_tready !== 1'b0) $display("FAIL rstmid_forward_gate: got tvalid=%0b tready=%0b want 1 0", m_tvalid, s_tready); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      chk_cnt++; if (m_tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_async_clear: got tvalid=%0b busy=%0b want 0 0", m_tvalid, busy); else pass_cnt++;
      chk_cnt++; if (m_hdr_valid !== 1'b0 || arp_request_valid !== 1'b0 || m_eth_dest_mac !== 48'h0) $display("FAIL rstmid_outputs: got hv=%0b av=%0b mac=%h want 0 0 0", m_hdr_valid, arp_request_valid, m_eth_dest_mac); else pass_cnt++;
      @(negedge clk);
      s_tvalid = 1'b0; s_ip_hdr_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      do_frame(32'h0A000006, 48'h020000000006, 1'b0, 1, 1'b0, hl, sa, rip, gm, fb, ab, ep, tm);
      chk_cnt++; if (sa !== 1'b1 || tm) $display("FAIL rstmid_first_miss: got arp=%0b tmo=%0b want 1 0", sa, tm); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_repeat_hit();
      test_eviction();
      test_arp_error();
      test_aging();
      test_flush();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
